multibyte_compare_seq: RTL and testbench

Downstream consumer of the 8-bit magnitude comparator. It takes a stream of per-byte greater/equal/less flags, presented most-significant byte first, and accumulates them into one magnitude verdict for a NUM_BYTES-wide operand pair. It uses a valid/ready handshake on both the input and the result side. A wide compare is built by time-multiplexing a single 8-bit comparator instead of replicating it.

---
 rtl/multibyte_compare_seq.sv | 178 +++++++++++++++++
 tb/tb_multibyte_compare_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multibyte_compare_seq.sv
// multibyte_compare_seq
//
// Folds a stream of per-byte magnitude flags (most-significant byte first)
// from a single 8-bit comparator into one verdict for a NUM_BYTES-wide
// operand pair.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both 1. The producer holds its data while valid=1 and ready=0. Input
// side: in_valid/in_ready, where in_ready = !res_valid. Result side:
// res_valid/res_ready, where the result is held stable until it is taken.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_g/in_e/in_l      byte flags a>b, a==b, a<b
//   in_valid, in_ready  input handshake
//   flush               synchronous abort of the current pair; it drops
//                       the byte presented in the same cycle
//   res_g/res_e/res_l   wide verdict A>B, A==B, A<B
//   res_err             some byte in the pair had a flag vector that was
//                       not one-hot
//   res_valid,res_ready result handshake
//   dbg_state           current FSM state (IDLE=0 ACCUM=1 DECIDED=2 DONE=3)
module multibyte_compare_seq #(
  parameter int NUM_BYTES = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_g,
  input  logic       in_e,
  input  logic       in_l,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic       res_g,
  output logic       res_e,
  output logic       res_l,
  output logic       res_err,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_DECIDED = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  state_t           r_state,     w_state_n;
  logic [CNT_W-1:0] r_cnt,       w_cnt_n;
  logic             r_lock,      w_lock_n;    // a byte has decided the pair
  logic             r_lock_g,    w_lock_g_n;  // locked verdict: 1=A>B, 0=A<B
  logic             r_err,       w_err_n;
  logic             r_res_g,     w_res_g_n;
  logic             r_res_e,     w_res_e_n;
  logic             r_res_l,     w_res_l_n;
  logic             r_res_err,   w_res_err_n;
  logic             r_res_valid, w_res_valid_n;

  logic             w_accept;
  logic             w_onehot;
  logic             w_last;

  assign in_ready  = !r_res_valid;
  assign w_accept  = in_valid && in_ready;
  assign w_onehot  = ({in_g, in_e, in_l} == 3'b100) ||
                     ({in_g, in_e, in_l} == 3'b010) ||
                     ({in_g, in_e, in_l} == 3'b001);
  assign w_last    = (r_cnt == LAST_IDX);

  assign res_g     = r_res_g;
  assign res_e     = r_res_e;
  assign res_l     = r_res_l;
  assign res_err   = r_res_err;
  assign res_valid = r_res_valid;
  assign dbg_state = r_state;

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_lock_n      = r_lock;
    w_lock_g_n    = r_lock_g;
    w_err_n       = r_err;
    w_res_g_n     = r_res_g;
    w_res_e_n     = r_res_e;
    w_res_l_n     = r_res_l;
    w_res_err_n   = r_res_err;
    w_res_valid_n = r_res_valid;

    if (flush) begin
      // Flush wins over an accept or a result handshake in the same cycle.
      w_state_n     = S_IDLE;
      w_cnt_n       = '0;
      w_lock_n      = 1'b0;
      w_lock_g_n    = 1'b0;
      w_err_n       = 1'b0;
      w_res_g_n     = 1'b0;
      w_res_e_n     = 1'b0;
      w_res_l_n     = 1'b0;
      w_res_err_n   = 1'b0;
      w_res_valid_n = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM, S_DECIDED: begin
          if (w_accept) begin
            w_cnt_n = r_cnt + CNT_W'(1);
            if (!w_onehot) begin
              // Bad code: poison the pair but leave the lock alone.
              w_err_n = 1'b1;
            end else if (!r_lock && !in_e) begin
              w_lock_n   = 1'b1;
              w_lock_g_n = in_g;
            end
            if (w_last) begin
              // The result is registered on the edge that takes the last byte.
              w_state_n     = S_DONE;
              w_res_valid_n = 1'b1;
              w_res_err_n   = w_err_n;
              w_res_g_n     = !w_err_n && w_lock_n && w_lock_g_n;
              w_res_l_n     = !w_err_n && w_lock_n && !w_lock_g_n;
              w_res_e_n     = !w_err_n && !w_lock_n;
            end else begin
              w_state_n = w_lock_n ? S_DECIDED : S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (r_res_valid && res_ready) begin
            w_state_n     = S_IDLE;
            w_cnt_n       = '0;
            w_lock_n      = 1'b0;
            w_lock_g_n    = 1'b0;
            w_err_n       = 1'b0;
            w_res_g_n     = 1'b0;
            w_res_e_n     = 1'b0;
            w_res_l_n     = 1'b0;
            w_res_err_n   = 1'b0;
            w_res_valid_n = 1'b0;
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lock      <= 1'b0;
      r_lock_g    <= 1'b0;
      r_err       <= 1'b0;
      r_res_g     <= 1'b0;
      r_res_e     <= 1'b0;
      r_res_l     <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_lock      <= w_lock_n;
      r_lock_g    <= w_lock_g_n;
      r_err       <= w_err_n;
      r_res_g     <= w_res_g_n;
      r_res_e     <= w_res_e_n;
      r_res_l     <= w_res_l_n;
      r_res_err   <= w_res_err_n;
      r_res_valid <= w_res_valid_n;
    end
  end

endmodule

// File: tb/tb_multibyte_compare_seq.sv
// Directed bench for multibyte_compare_seq with NUM_BYTES=4.
// Result vector layout used in checks: {res_g, res_e, res_l, res_err, res_valid}.
module tb_multibyte_compare_seq;

  logic       clk;
  logic       rst_n;
  logic       in_g, in_e, in_l;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic       res_g, res_e, res_l, res_err, res_valid;
  logic       res_ready;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [2:0] F_G   = 3'b100;
  localparam logic [2:0] F_E   = 3'b010;
  localparam logic [2:0] F_L   = 3'b001;
  localparam logic [2:0] F_BAD = 3'b110;

  localparam logic [4:0] R_NONE = 5'b00000;
  localparam logic [4:0] R_G    = 5'b10001;
  localparam logic [4:0] R_E    = 5'b01001;
  localparam logic [4:0] R_L    = 5'b00101;
  localparam logic [4:0] R_ERR  = 5'b00011;

  multibyte_compare_seq #(.NUM_BYTES(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_g      (in_g),
    .in_e      (in_e),
    .in_l      (in_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .res_g     (res_g),
    .res_e     (res_e),
    .res_l     (res_l),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] res_vec();
    return {res_g, res_e, res_l, res_err, res_valid};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: offer one byte for one cycle, return #1 after the edge.
  task automatic send(input logic [2:0] f);
    {in_g, in_e, in_l} = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    {in_g, in_e, in_l} = 3'b000;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_g = 1'b0; in_e = 1'b0; in_l = 1'b0;
    in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;

    // Reset state
    #12;
    chk("reset_res", 8'(res_vec()), 8'(R_NONE));
    rst_n = 1'b1;
    idle_cycle();
    chk("reset_in_ready", 8'(in_ready), 8'd1);
    chk("reset_state", 8'(dbg_state), 8'd0);

    // e,e,e,l -> A<B, valid for exactly one cycle
    send(F_E); send(F_E); send(F_E);
    chk("eeel_not_early", 8'(res_vec()), 8'(R_NONE));
    send(F_L);
    chk("eeel_result", 8'(res_vec()), 8'(R_L));
    chk("eeel_in_ready", 8'(in_ready), 8'd0);
    idle_cycle();
    chk("eeel_one_cycle", 8'(res_valid), 8'd0);
    chk("eeel_ready_back", 8'(in_ready), 8'd1);

    // g,l,l,l -> early lock holds
    send(F_G); send(F_L); send(F_L); send(F_L);
    chk("glll_result", 8'(res_vec()), 8'(R_G));
    idle_cycle();

    // Back-to-back: e,e,e,e starts right after the handshake cycle
    send(F_E); send(F_E); send(F_E); send(F_E);
    chk("eeee_result", 8'(res_vec()), 8'(R_E));
    idle_cycle();
    chk("eeee_cleared", 8'(res_vec()), 8'(R_NONE));

    // Backpressure: e,g,e,e with res_ready low for 5 cycles, bytes offered
    res_ready = 1'b0;
    send(F_E); send(F_G); send(F_E); send(F_E);
    chk("bp_result", 8'(res_vec()), 8'(R_G));
    for (int i = 0; i < 5; i++) begin
      {in_g, in_e, in_l} = F_L;
      in_valid = 1'b1;
      idle_cycle();
      chk("bp_hold_res", 8'(res_vec()), 8'(R_G));
      chk("bp_hold_ready", 8'(in_ready), 8'd0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    idle_cycle();
    chk("bp_release_valid", 8'(res_valid), 8'd0);
    chk("bp_release_ready", 8'(in_ready), 8'd1);

    // Invalid code: e,110,e,l -> error; next pair clears it
    send(F_E); send(F_BAD); send(F_E); send(F_L);
    chk("bad_result", 8'(res_vec()), 8'(R_ERR));
    idle_cycle();
    send(F_E); send(F_E); send(F_E);
    chk("post_bad_not_early", 8'(res_vec()), 8'(R_NONE));
    send(F_G);
    chk("post_bad_result", 8'(res_vec()), 8'(R_G));
    idle_cycle();

    // Flush with a third byte: byte dropped, no result
    send(F_G); send(F_E);
    flush = 1'b1;
    send(F_E);
    flush = 1'b0;
    chk("flush_no_result", 8'(res_vec()), 8'(R_NONE));
    chk("flush_state", 8'(dbg_state), 8'd0);
    send(F_L); send(F_E); send(F_E);
    chk("flush_cnt_restart", 8'(res_vec()), 8'(R_NONE));
    send(F_E);
    chk("flush_next_result", 8'(res_vec()), 8'(R_L));
    idle_cycle();

    // Asynchronous reset mid-pair after g,e
    send(F_G); send(F_E);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_res", 8'(res_vec()), 8'(R_NONE));
    chk("rst_mid_state", 8'(dbg_state), 8'd0);
    #3;
    rst_n = 1'b1;
    idle_cycle();
    send(F_E); send(F_E); send(F_E);
    chk("rst_cnt_restart", 8'(res_vec()), 8'(R_NONE));
    send(F_E);
    chk("rst_no_stale", 8'(res_vec()), 8'(R_E));
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
